gray_count_monitor: RTL and testbench
=====================================

// Module: gray_count_monitor
// PURPOSE
//  Downstream consumer of the free-running 8-bit Gray counter. Synchronises the Gray code into
//  the local clk domain, decodes it to binary, and checks that every change is a single-bit,
//  +1-step. Emits one step pulse per valid increment, a sticky error on any illegal transition,
//  and a stall flag when the counter stops advancing. Feeds status LEDs and the debug register bank.
// PARAMETERS
//  W            8        Gray code width
//  SYNC_STAGES  2        synchroniser flops on gray_in (legal 2..4)
//  STALL_CYCLES 2**27    clk cycles without a code change before stall asserts
//  ERR_CNT_W    8        width of the error counter (used only with GRAY_MON_ERR_CNT_EN)
// PORTS
//  clk        in   1          single clock; all logic on posedge clk
//  reset      in   1          asynchronous, active-high reset
//  gray_in    in   W          Gray count from the upstream counter; asynchronous to clk
//  clear      in   1          synchronous clear of err, stall and err_count
//  bin_out    out  W          binary value of the last sampled code
//  step       out  1          1-cycle pulse per accepted +1 transition; 255->0 wrap is legal
//  err        out  1          sticky illegal-transition flag
//  stall      out  1          no code change for STALL_CYCLES cycles
//  state      out  2          FSM state: 0 ACQUIRE, 1 TRACK, 2 ERROR
//  err_count  out  ERR_CNT_W  saturating illegal-transition count (only with GRAY_MON_ERR_CNT_EN)
// BEHAVIOUR
//  - Reset: sync chain, g_prev, bin_out, step, err, stall, stall counter, err_count = 0; state = ACQUIRE.
//  - g_s = last sync-chain stage; diff = g_s ^ g_prev; b_new = gray2bin(g_s); b_old = gray2bin(g_prev).
//  - ACQUIRE: waits SYNC_STAGES+1 cycles after reset release, then latches g_s into g_prev and
//    b_new into bin_out, and moves to TRACK. No step, no err during ACQUIRE.
//  - TRACK/ERROR, each cycle:
//    diff==0: no change; stall counter++ (saturates); stall=1 once counter == STALL_CYCLES.
//    popcount(diff)==1 and b_new == b_old+1 mod 2^W: valid; step=1 next cycle, bin_out=b_new.
//    any other diff (multi-bit change, or decrement): illegal; err=1, state->ERROR, bin_out=b_new
//      (resync), no step. g_prev <= g_s in both the valid and illegal cases.
//    Any change (valid or illegal) clears the stall counter and stall in the same cycle.
//  - ERROR keeps tracking: valid steps still pulse step; err stays 1 until clear.
//  - clear: err=0, stall=0, stall counter=0, err_count=0; ERROR->TRACK; ignored in ACQUIRE.
//  - clear with a simultaneous illegal transition: the error wins; err=1, state stays/enters ERROR,
//    err_count=1.
//  - Latency: gray_in edge -> step/bin_out update = SYNC_STAGES+1 clk cycles.
//  - Reset asserted mid-operation: all outputs return to reset values immediately, and the FSM
//    re-runs ACQUIRE.
// CONFIGURATION
//  GRAY_MON_ERR_CNT_EN defined: err_count port present; increments on each illegal transition,
//    saturates at 2^ERR_CNT_W-1, and is cleared by clear or reset.
//  Not defined: err_count port and counter absent; all other behaviour identical.
// STRUCTURE
//  Shared package gray_pkg: state encodings (ST_ACQUIRE/ST_TRACK/ST_ERROR), gray2bin and bin2gray
//    functions, and a popcount function. These are shared with the upstream counter and its bench.
//  One sub-module: gray_sync (W-bit, SYNC_STAGES-deep flop chain, async active-high reset).
//  Top level holds the FSM, the transition checker, the stall counter and the optional error counter.
// TESTING  (bench: W=8, SYNC_STAGES=2, STALL_CYCLES=16)
//  1 Reset, then drive gray_in=bin2gray(0..255) and wrap to 0, each held 20 clk -> 256 step pulses,
//    err=0, bin_out tracks 0..255,0, and each step arrives 3 cycles after its gray_in edge.
//  2 In TRACK with gray_in=0x03 (bin 2), drive 0x06 (bin 4, two bits flip) -> err=1, state=ERROR,
//    bin_out=4, no step.
//  3 In TRACK, step back from 0x02 (bin 3) to 0x03 (bin 2) -> err=1, no step; then a valid +1
//    -> step pulses, err stays 1; pulse clear -> err=0, state=TRACK.
//  4 Hold gray_in constant for 16 cycles after a step -> stall=1; next valid change -> stall=0 in
//    the same cycle as the bin_out update.
//  5 Assert clear in the same cycle an illegal transition is detected -> err=1, state=ERROR,
//    err_count=1 (with GRAY_MON_ERR_CNT_EN).
//  6 Assert reset mid-count (bin_out=0x55) -> all outputs 0 asynchronously, state=ACQUIRE; after
//    release, bin_out takes the current code in 3 cycles with no step or err.

Source files
------------

// File: rtl/gray_pkg.sv
// Purpose: shared definitions for the Gray counter and its monitor: FSM state encodings,
//          Gray/binary conversion and a popcount helper.
// Ports:   none (package).
// Conversion helpers work on MAX_W-bit values; callers zero-extend narrower codes, which
// leaves the low bits of the result unchanged.
package gray_pkg;

  localparam int unsigned MAX_W = 32;

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'd0,
    ST_TRACK   = 2'd1,
    ST_ERROR   = 2'd2
  } state_e;

  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b = g;
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [5:0] popcount(input logic [MAX_W-1:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < int'(MAX_W); i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/gray_count_monitor_if.sv
// Purpose: signal bundle between the Gray count monitor and its consumer.
// Ports (signals):
//   gray_in   W          Gray code from the upstream counter (asynchronous to clk)
//   clear     1          synchronous clear of err/stall/err_count
//   bin_out   W          decoded binary value of the last sampled code
//   step      1          one-cycle pulse per accepted +1 transition
//   err       1          sticky illegal-transition flag
//   stall     1          counter stopped advancing
//   state     2          monitor FSM state
//   err_count ERR_CNT_W  saturating error count, only when GRAY_MON_ERR_CNT_EN is defined
// Modports: master = side driving gray_in/clear, slave = the monitor.
interface gray_count_monitor_if #(
  parameter int unsigned W = 8
`ifdef GRAY_MON_ERR_CNT_EN
  , parameter int unsigned ERR_CNT_W = 8
`endif
);

  logic [W-1:0] gray_in;
  logic         clear;
  logic [W-1:0] bin_out;
  logic         step;
  logic         err;
  logic         stall;
  logic [1:0]   state;
`ifdef GRAY_MON_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_count;
`endif

  modport master (
    output gray_in, clear,
    input  bin_out, step, err, stall, state
`ifdef GRAY_MON_ERR_CNT_EN
    , input err_count
`endif
  );

  modport slave (
    input  gray_in, clear,
    output bin_out, step, err, stall, state
`ifdef GRAY_MON_ERR_CNT_EN
    , output err_count
`endif
  );

endinterface

// File: rtl/gray_sync.sv
// Purpose: STAGES-deep flop chain bringing a Gray code into the local clock domain. Gray code
//          changes one bit at a time, so a multi-bit synchroniser is safe here.
// Ports:
//   i_clk    clock
//   i_reset  asynchronous active-high reset
//   i_d      asynchronous W-bit input
//   o_q      synchronised W-bit output (last stage)
module gray_sync #(
  parameter int unsigned W      = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [STAGES-1:0][W-1:0] r_chain;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/gray_count_monitor.sv
// Purpose: monitors a free-running Gray counter from another clock domain. Synchronises and
//          decodes the code, pulses step on each +1 transition, flags illegal transitions
//          (sticky err) and raises stall when the code stops changing.
// Optional feature: define GRAY_MON_ERR_CNT_EN to add the saturating err_count output.
// Ports:
//   i_clk    clock, all logic on its rising edge
//   i_reset  asynchronous active-high reset
//   io_bus   gray_count_monitor_if.slave (gray_in, clear in; bin_out, step, err, stall,
//            state, optional err_count out)
module gray_count_monitor
  import gray_pkg::*;
#(
  parameter int unsigned W            = 8,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned STALL_CYCLES = 2**27
`ifdef GRAY_MON_ERR_CNT_EN
  , parameter int unsigned ERR_CNT_W  = 8
`endif
) (
  input logic                 i_clk,
  input logic                 i_reset,
  gray_count_monitor_if.slave io_bus
);

  localparam int unsigned STALL_W = $clog2(STALL_CYCLES + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_CYCLES);
  // ACQUIRE lasts SYNC_STAGES+1 cycles: the chain fills, then the code is latched.
  localparam logic [2:0] ACQ_LAST = 3'(SYNC_STAGES);

  logic [W-1:0]       w_gs;
  logic [W-1:0]       w_diff;
  logic [W-1:0]       w_b_new;
  logic [W-1:0]       w_b_old;
  logic [W-1:0]       w_b_inc;
  logic               w_change;
  logic               w_valid;

  state_e             r_state, w_state_d;
  logic [2:0]         r_acq_cnt, w_acq_cnt_d;
  logic [W-1:0]       r_g_prev, w_g_prev_d;
  logic [W-1:0]       r_bin, w_bin_d;
  logic               r_step, w_step_d;
  logic               r_err, w_err_d;
  logic               r_stall, w_stall_d;
  logic [STALL_W-1:0] r_stall_cnt, w_stall_cnt_d;
`ifdef GRAY_MON_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] r_err_cnt, w_err_cnt_d;
`endif

  gray_sync #(
    .W      (W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (io_bus.gray_in),
    .o_q     (w_gs)
  );

  assign w_diff   = w_gs ^ r_g_prev;
  assign w_b_new  = W'(gray2bin(MAX_W'(w_gs)));
  assign w_b_old  = W'(gray2bin(MAX_W'(r_g_prev)));
  assign w_b_inc  = w_b_old + W'(1);
  assign w_change = |w_diff;
  assign w_valid  = (popcount(MAX_W'(w_diff)) == 6'd1) && (w_b_new == w_b_inc);

  always_comb begin
    w_state_d     = r_state;
    w_acq_cnt_d   = r_acq_cnt;
    w_g_prev_d    = r_g_prev;
    w_bin_d       = r_bin;
    w_step_d      = 1'b0;
    w_err_d       = r_err;
    w_stall_d     = r_stall;
    w_stall_cnt_d = r_stall_cnt;
`ifdef GRAY_MON_ERR_CNT_EN
    w_err_cnt_d   = r_err_cnt;
`endif

    unique case (r_state)
      ST_ACQUIRE: begin
        if (r_acq_cnt == ACQ_LAST) begin
          w_g_prev_d = w_gs;
          w_bin_d    = w_b_new;
          w_state_d  = ST_TRACK;
        end else begin
          w_acq_cnt_d = r_acq_cnt + 3'd1;
        end
      end
      ST_TRACK, ST_ERROR: begin
        // Clear is applied first so a simultaneous illegal transition overrides it.
        if (io_bus.clear) begin
          w_err_d       = 1'b0;
          w_stall_d     = 1'b0;
          w_stall_cnt_d = '0;
          w_state_d     = ST_TRACK;
`ifdef GRAY_MON_ERR_CNT_EN
          w_err_cnt_d   = '0;
`endif
        end
        if (!w_change) begin
          if (!io_bus.clear && (r_stall_cnt != STALL_MAX)) begin
            w_stall_cnt_d = r_stall_cnt + STALL_W'(1);
          end
          if (w_stall_cnt_d == STALL_MAX) begin
            w_stall_d = 1'b1;
          end
        end else begin
          // Resync to the new code on any change, legal or not.
          w_g_prev_d    = w_gs;
          w_bin_d       = w_b_new;
          w_stall_cnt_d = '0;
          w_stall_d     = 1'b0;
          if (w_valid) begin
            w_step_d = 1'b1;
          end else begin
            w_err_d   = 1'b1;
            w_state_d = ST_ERROR;
`ifdef GRAY_MON_ERR_CNT_EN
            if (w_err_cnt_d != '1) begin
              w_err_cnt_d = w_err_cnt_d + ERR_CNT_W'(1);
            end
`endif
          end
        end
      end
      default: begin
        w_state_d   = ST_ACQUIRE;
        w_acq_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_ACQUIRE;
      r_acq_cnt   <= '0;
      r_g_prev    <= '0;
      r_bin       <= '0;
      r_step      <= 1'b0;
      r_err       <= 1'b0;
      r_stall     <= 1'b0;
      r_stall_cnt <= '0;
`ifdef GRAY_MON_ERR_CNT_EN
      r_err_cnt   <= '0;
`endif
    end else begin
      r_state     <= w_state_d;
      r_acq_cnt   <= w_acq_cnt_d;
      r_g_prev    <= w_g_prev_d;
      r_bin       <= w_bin_d;
      r_step      <= w_step_d;
      r_err       <= w_err_d;
      r_stall     <= w_stall_d;
      r_stall_cnt <= w_stall_cnt_d;
`ifdef GRAY_MON_ERR_CNT_EN
      r_err_cnt   <= w_err_cnt_d;
`endif
    end
  end

  assign io_bus.bin_out = r_bin;
  assign io_bus.step    = r_step;
  assign io_bus.err     = r_err;
  assign io_bus.stall   = r_stall;
  assign io_bus.state   = r_state;
`ifdef GRAY_MON_ERR_CNT_EN
  assign io_bus.err_count = r_err_cnt;
`endif

endmodule

// File: tb/tb_gray_count_monitor.sv
// Directed bench for gray_count_monitor (W=8, SYNC_STAGES=2, STALL_CYCLES=16).
// Honours GRAY_MON_ERR_CNT_EN for the err_count checks.
module tb_gray_count_monitor;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_mis;
  int   n_step_seen;
  int   base;
  int   lat;

`ifdef GRAY_MON_ERR_CNT_EN
  gray_count_monitor_if #(.W(8), .ERR_CNT_W(8)) bus ();
`else
  gray_count_monitor_if #(.W(8)) bus ();
`endif

`ifdef GRAY_MON_ERR_CNT_EN
  gray_count_monitor #(.W(8), .SYNC_STAGES(2), .STALL_CYCLES(16), .ERR_CNT_W(8)) dut (
`else
  gray_count_monitor #(.W(8), .SYNC_STAGES(2), .STALL_CYCLES(16)) dut (
`endif
    .i_clk   (clk),
    .i_reset (reset),
    .io_bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  function automatic logic [7:0] gray_of(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.step === 1'b1) n_step_seen++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  initial begin
    n_cmp       = 0;
    n_mis       = 0;
    n_step_seen = 0;
    reset       = 1'b1;
    bus.gray_in = 8'h00;
    bus.clear   = 1'b0;

    // Reset values
    ticks(3);
    chk("rst_bin", bus.bin_out, 0);
    chk("rst_step", bus.step, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_state", bus.state, 0);
`ifdef GRAY_MON_ERR_CNT_EN
    chk("rst_errcnt", bus.err_count, 0);
`endif
    reset = 1'b0;
    ticks(2);
    chk("acq_wait_state", bus.state, 0);
    tick();
    chk("acq_done_state", bus.state, 1);
    chk("acq_done_bin", bus.bin_out, 0);

    // 1: full count 1..255 then wrap to 0, 20 clocks per code
    n_step_seen = 0;
    for (int k = 1; k <= 256; k++) begin
      logic [7:0] v;
      v           = k[7:0];
      bus.gray_in = gray_of(v);
      base        = n_step_seen;
      lat         = 0;
      for (int c = 1; c <= 20; c++) begin
        tick();
        if (lat == 0 && n_step_seen != base) lat = c;
      end
      chk("t1_latency", lat, 3);
      chk("t1_bin", bus.bin_out, {24'd0, v});
      chk("t1_err", bus.err, 0);
    end
    chk("t1_steps", n_step_seen, 256);

    // 2: 0x03 (bin 2) -> 0x06 (bin 4): two bits flip
    bus.gray_in = 8'h01;
    ticks(20);
    bus.gray_in = 8'h03;
    ticks(20);
    chk("t2_pre_bin", bus.bin_out, 2);
    base        = n_step_seen;
    bus.gray_in = 8'h06;
    ticks(3);
    chk("t2_err", bus.err, 1);
    chk("t2_state", bus.state, 2);
    chk("t2_bin", bus.bin_out, 4);
    chk("t2_nostep", n_step_seen - base, 0);
    pulse_clear();
    chk("t2_clr_err", bus.err, 0);
    chk("t2_clr_state", bus.state, 1);

    // 3: re-acquire at 0x02 (bin 3), step back to 0x03 (bin 2), then forward again
    reset       = 1'b1;
    bus.gray_in = 8'h02;
    ticks(2);
    reset = 1'b0;
    base  = n_step_seen;
    ticks(3);
    chk("t3_acq_state", bus.state, 1);
    chk("t3_acq_bin", bus.bin_out, 3);
    chk("t3_acq_nostep", n_step_seen - base, 0);
    ticks(2);
    base        = n_step_seen;
    bus.gray_in = 8'h03;
    ticks(3);
    chk("t3_dec_err", bus.err, 1);
    chk("t3_dec_state", bus.state, 2);
    chk("t3_dec_bin", bus.bin_out, 2);
    ticks(5);
    chk("t3_dec_nostep", n_step_seen - base, 0);
    bus.gray_in = 8'h02;
    ticks(3);
    chk("t3_inc_step", bus.step, 1);
    chk("t3_inc_bin", bus.bin_out, 3);
    chk("t3_inc_err", bus.err, 1);
    chk("t3_inc_state", bus.state, 2);
    pulse_clear();
    chk("t3_clr_err", bus.err, 0);
    chk("t3_clr_state", bus.state, 1);

    // 4: stall after 16 unchanged cycles, cleared with the next bin_out update
    bus.gray_in = 8'h06;
    ticks(3);
    chk("t4_step", bus.step, 1);
    chk("t4_bin", bus.bin_out, 4);
    ticks(15);
    chk("t4_stall_early", bus.stall, 0);
    tick();
    chk("t4_stall_set", bus.stall, 1);
    ticks(5);
    bus.gray_in = 8'h07;
    ticks(2);
    chk("t4_stall_hold", bus.stall, 1);
    chk("t4_bin_hold", bus.bin_out, 4);
    tick();
    chk("t4_stall_clr", bus.stall, 0);
    chk("t4_bin_upd", bus.bin_out, 5);
    chk("t4_step2", bus.step, 1);

    // 5: single-bit flip that is not +1 (bin 5 -> 10), then illegal with clear coincident
    ticks(2);
    bus.gray_in = 8'h0F;
    ticks(3);
    chk("t5_flip_err", bus.err, 1);
    chk("t5_flip_bin", bus.bin_out, 8'h0A);
`ifdef GRAY_MON_ERR_CNT_EN
    chk("t5_flip_errcnt", bus.err_count, 1);
`endif
    ticks(3);
    bus.gray_in = 8'h00;
    ticks(2);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("t5_clr_err", bus.err, 1);
    chk("t5_clr_state", bus.state, 2);
    chk("t5_clr_bin", bus.bin_out, 0);
`ifdef GRAY_MON_ERR_CNT_EN
    chk("t5_clr_errcnt", bus.err_count, 1);
`endif

    // 6: asynchronous reset at bin_out 0x55, then re-acquire
    ticks(2);
    bus.gray_in = 8'h7F;
    ticks(3);
    chk("t6_pre_bin", bus.bin_out, 8'h55);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_bin", bus.bin_out, 0);
    chk("t6_rst_step", bus.step, 0);
    chk("t6_rst_err", bus.err, 0);
    chk("t6_rst_stall", bus.stall, 0);
    chk("t6_rst_state", bus.state, 0);
`ifdef GRAY_MON_ERR_CNT_EN
    chk("t6_rst_errcnt", bus.err_count, 0);
`endif
    bus.gray_in = 8'h7E;
    ticks(2);
    reset = 1'b0;
    base  = n_step_seen;
    ticks(2);
    chk("t6_acq_state", bus.state, 0);
    chk("t6_acq_bin", bus.bin_out, 0);
    tick();
    chk("t6_done_state", bus.state, 1);
    chk("t6_done_bin", bus.bin_out, 8'h54);
    chk("t6_done_err", bus.err, 0);
    chk("t6_nostep", n_step_seen - base, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
